wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Write-back side of the execute->WB handshake. Collects results from NUM_SRC execution units
//  (ALU, BRU, MDU, LSU), each a pip_wb_interface master holding valid/data/csrdata/itag until ready.
//  Grants one result per cycle round-robin and registers it onto the single ROB/regfile write port.
// PARAMETERS
//  NUM_SRC   4    number of execution-unit write-back sources (2..8)
//  XLEN      64   data / csrdata width
//  ITAG_W    8    instruction tag width
// PORTS
//  clk_i          in   1                 clock, all logic on rising edge
//  arst_ni        in   1                 asynchronous reset, active low
//  flush_i        in   1                 pipeline flush (flush_slave.flush)
//  src_valid_i    in   NUM_SRC           per-source result valid
//  src_data_i     in   NUM_SRC*XLEN      per-source result data
//  src_csrdata_i  in   NUM_SRC*XLEN      per-source CSR write data
//  src_itag_i     in   NUM_SRC*ITAG_W    per-source instruction tag
//  src_ready_o    out  NUM_SRC           per-source accept (the wb_interface ready), one-hot or zero
//  wb_valid_o     out  1                 registered result valid to ROB
//  wb_data_o      out  XLEN              registered result data
//  wb_csrdata_o   out  XLEN              registered CSR data
//  wb_itag_o      out  ITAG_W            registered tag
//  wb_src_o       out  $clog2(NUM_SRC)   index of source that produced the result
//  wb_ready_i     in   1                 ROB accepts the current result
// BEHAVIOUR
//  - Reset (arst_ni=0, async): wb_valid_o=0, rr_ptr=0; data/csrdata/itag/src regs are don't-care,
//    no reset required. src_ready_o is 0 while in reset.
//  - can_load = !wb_valid_o | wb_ready_i. Output register loads only when can_load.
//  - Arbitration (comb): among src_valid_i, the first set bit at or after rr_ptr (wrapping) wins.
//    src_ready_o = grant & {NUM_SRC{can_load & !flush_i}}. Never more than one ready bit set.
//  - Transfer on src i when src_valid_i[i] & src_ready_o[i]. Next cycle: wb_valid_o=1, payload =
//    source i's fields, wb_src_o=i. Latency 1 cycle; throughput 1 result/cycle with wb_ready_i=1.
//  - rr_ptr <= (i+1) mod NUM_SRC only on a transfer; unchanged otherwise (no grant-without-accept).
//  - Output hold: wb_valid_o=1 & wb_ready_i=0 -> all outputs stable, all src_ready_o=0.
//  - wb_valid_o=1 & wb_ready_i=1 with no source valid -> wb_valid_o<=0.
//  - Flush (sync, priority over everything but reset): wb_valid_o<=0, no transfer that cycle
//    (ready forced 0), rr_ptr unchanged. Sources flush themselves in the same cycle.
//  - A source that drops valid without ready is a protocol error; assert-only, not handled.
//  - Arithmetic: NUM_SRC not a power of 2 -> rr_ptr wraps explicitly from NUM_SRC-1 to 0.
// STRUCTURE
//  - prv664_define.svh / shared pkg: wb_payload_t struct {data, csrdata, itag}, WB_SRC_* index
//    constants (ALU=0, BRU=1, MDU=2, LSU=3).
//  - Sub-module rr_arbiter #(N): inputs req, ptr, outputs one-hot grant and grant index;
//    pure comb (double-width mask trick). Reusable for issue-queue select.
//  - Top: can_load logic, rr_ptr register, output register, SVA (one-hot ready, stable hold).
// TESTING
//  1 Reset: arst_ni low mid-transfer with src_valid_i=4'b1111 -> wb_valid_o=0 immediately,
//    src_ready_o=0; after release first grant goes to src0.
//  2 Fairness: src_valid_i=4'b1111 held, wb_ready_i=1 -> wb_src_o sequence 0,1,2,3,0 on
//    consecutive cycles, one result per cycle.
//  3 Backpressure: result itag=8'h12 in output, wb_ready_i=0 for 3 cycles -> outputs stable,
//    src_ready_o=0; wb_ready_i=1 -> next granted source (itag 8'h34) appears the following cycle.
//  4 Skip idle: rr_ptr=1, src_valid_i=4'b0001 -> src0 granted (wrap), rr_ptr becomes 1 again.
//  5 Flush: wb_valid_o=1, src_valid_i=4'b0110, flush_i=1 -> next cycle wb_valid_o=0, no ready
//    pulsed, rr_ptr unchanged.
//  6 Drain: single ALU result data=64'hFFFF_FFFF_8000_0000 -> appears unchanged one cycle later,
//    wb_valid_o drops the cycle after wb_ready_i with no new requests.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared write-back definitions: default widths, execution-unit source indices
// and the payload carried from an execution unit to the ROB/regfile port.
package wb_arbiter_pkg;

  localparam int WB_NUM_SRC = 4;
  localparam int WB_XLEN    = 64;
  localparam int WB_ITAG_W  = 8;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_BRU = 1;
  localparam int WB_SRC_MDU = 2;
  localparam int WB_SRC_LSU = 3;

  typedef struct packed {
    logic [WB_XLEN-1:0]   data;
    logic [WB_XLEN-1:0]   csrdata;
    logic [WB_ITAG_W-1:0] itag;
  } wb_payload_t;

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin selector: the first requester at or after ptr wins,
// wrapping past N-1. Shared by the write-back arbiter and issue-queue select.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_vld
);

  localparam int IDX_W = $clog2(N);
  localparam logic [2*N-1:0] ONE = (2*N)'(1);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] lowest;

  // The upper copy of req catches requests below ptr once the lower copy is masked off.
  assign req_dbl = {req, req};
  assign mask    = ~((ONE << ptr) - ONE);
  assign masked  = req_dbl & mask;
  assign lowest  = masked & (~masked + ONE);

  assign grant     = lowest[N-1:0] | lowest[2*N-1:N];
  assign grant_vld = |req;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: picks one execution-unit result per cycle round-robin and
// registers it onto the single ROB/regfile write port with valid/ready backpressure.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = WB_NUM_SRC,
  parameter int XLEN    = WB_XLEN,
  parameter int ITAG_W  = WB_ITAG_W
) (
  input  logic                         clk_i,
  input  logic                         arst_ni,
  input  logic                         flush_i,
  input  logic [NUM_SRC-1:0]           src_valid_i,
  input  logic [NUM_SRC*XLEN-1:0]      src_data_i,
  input  logic [NUM_SRC*XLEN-1:0]      src_csrdata_i,
  input  logic [NUM_SRC*ITAG_W-1:0]    src_itag_i,
  output logic [NUM_SRC-1:0]           src_ready_o,
  output logic                         wb_valid_o,
  output logic [XLEN-1:0]              wb_data_o,
  output logic [XLEN-1:0]              wb_csrdata_o,
  output logic [ITAG_W-1:0]            wb_itag_o,
  output logic [$clog2(NUM_SRC)-1:0]   wb_src_o,
  input  logic                         wb_ready_i
);

  localparam int PTR_W = $clog2(NUM_SRC);

  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic [XLEN-1:0]   csrdata;
    logic [ITAG_W-1:0] itag;
  } payload_t;

  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_SRC-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_vld;
  logic               can_load;
  logic               accept_en;
  logic               xfer;
  payload_t           payload_p0;

  logic               vld_p1;
  payload_t           payload_p1;
  logic [PTR_W-1:0]   src_p1;

  // Explicit wrap keeps non-power-of-two source counts from indexing past the last unit.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx);
    if (idx == PTR_W'(NUM_SRC - 1)) return '0;
    return idx + 1'b1;
  endfunction

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .req       (src_valid_i),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Stage p0: select, handshake back to the winning source.
  assign can_load    = !vld_p1 | wb_ready_i;
  assign accept_en   = can_load & !flush_i & arst_ni;
  assign src_ready_o = grant & {NUM_SRC{accept_en}};
  assign xfer        = grant_vld & accept_en;

  always_comb begin
    payload_p0         = '0;
    payload_p0.data    = src_data_i[grant_idx*XLEN +: XLEN];
    payload_p0.csrdata = src_csrdata_i[grant_idx*XLEN +: XLEN];
    payload_p0.itag    = src_itag_i[grant_idx*ITAG_W +: ITAG_W];
  end

  // Stage p1: registered write-back port.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      vld_p1 <= 1'b0;
      rr_ptr <= '0;
    end else if (flush_i) begin
      vld_p1 <= 1'b0;
    end else if (can_load) begin
      vld_p1 <= xfer;
      if (xfer) rr_ptr <= rr_next(grant_idx);
    end
  end

  always_ff @(posedge clk_i) begin
    if (xfer) begin
      payload_p1 <= payload_p0;
      src_p1     <= grant_idx;
    end
  end

  assign wb_valid_o   = vld_p1;
  assign wb_data_o    = payload_p1.data;
  assign wb_csrdata_o = payload_p1.csrdata;
  assign wb_itag_o    = payload_p1.itag;
  assign wb_src_o     = src_p1;

  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!arst_ni)
    $onehot0(src_ready_o));

  a_hold_stable: assert property (@(posedge clk_i) disable iff (!arst_ni)
    (vld_p1 && !wb_ready_i && !flush_i) |=> (vld_p1 && $stable(payload_p1) && $stable(src_p1)));

  a_hold_no_ready: assert property (@(posedge clk_i) disable iff (!arst_ni)
    (vld_p1 && !wb_ready_i) |-> (src_ready_o == '0));

  a_flush_drops: assert property (@(posedge clk_i) disable iff (!arst_ni)
    flush_i |=> !vld_p1);

  // A source must hold its result until accepted, unless the pipeline flushes it.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src_proto
    a_src_hold: assert property (@(posedge clk_i) disable iff (!arst_ni)
      (src_valid_i[g] && !src_ready_o[g] && !flush_i) |=> src_valid_i[g]);
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, fairness, backpressure, wrap, flush, drain.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int XL = 64;
  localparam int TW = 8;
  localparam int PW = 2;

  logic            clk_i;
  logic            arst_ni;
  logic            flush_i;
  logic [N-1:0]    src_valid_i;
  logic [N*XL-1:0] src_data_i;
  logic [N*XL-1:0] src_csrdata_i;
  logic [N*TW-1:0] src_itag_i;
  logic [N-1:0]    src_ready_o;
  logic            wb_valid_o;
  logic [XL-1:0]   wb_data_o;
  logic [XL-1:0]   wb_csrdata_o;
  logic [TW-1:0]   wb_itag_o;
  logic [PW-1:0]   wb_src_o;
  logic            wb_ready_i;

  int total;
  int bad;

  logic [XL-1:0] d_ref [N];
  logic [XL-1:0] c_ref [N];
  logic [TW-1:0] t_ref [N];

  wb_arbiter #(.NUM_SRC(N), .XLEN(XL), .ITAG_W(TW)) dut (
    .clk_i         (clk_i),
    .arst_ni       (arst_ni),
    .flush_i       (flush_i),
    .src_valid_i   (src_valid_i),
    .src_data_i    (src_data_i),
    .src_csrdata_i (src_csrdata_i),
    .src_itag_i    (src_itag_i),
    .src_ready_o   (src_ready_o),
    .wb_valid_o    (wb_valid_o),
    .wb_data_o     (wb_data_o),
    .wb_csrdata_o  (wb_csrdata_o),
    .wb_itag_o     (wb_itag_o),
    .wb_src_o      (wb_src_o),
    .wb_ready_i    (wb_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic set_src(input int i, input logic [XL-1:0] d, input logic [XL-1:0] c,
                         input logic [TW-1:0] t);
    src_data_i[i*XL +: XL]    = d;
    src_csrdata_i[i*XL +: XL] = c;
    src_itag_i[i*TW +: TW]    = t;
    d_ref[i] = d;
    c_ref[i] = c;
    t_ref[i] = t;
  endtask

  task automatic default_srcs();
    for (int i = 0; i < N; i++)
      set_src(i, 64'hD000_0000_0000_0000 + 64'(i), 64'hC000_0000_0000_0000 + 64'(i), 8'h10 + 8'(i));
  endtask

  // Sources drop their pending results in the flush cycle.
  task automatic flush_idle();
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    src_valid_i = '0;
    flush_i = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    arst_ni = 1'b0;
    #1;
    arst_ni = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    src_valid_i = 4'b1111;
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want %b", wb_valid_o, 1'b0); end
    total++; if (src_ready_o !== 4'b0000) begin bad++; $display("FAIL rst_ready: got %b want %b", src_ready_o, 4'b0000); end
    arst_ni = 1'b1;
    #1;
    total++; if (src_ready_o !== 4'b0001) begin bad++; $display("FAIL rst_first_ready: got %b want %b", src_ready_o, 4'b0001); end
    @(posedge clk_i); #1;
    total++; if (wb_valid_o !== 1'b1 || wb_src_o !== 2'd0) begin bad++; $display("FAIL rst_first_out: got v=%b s=%0d want v=1 s=0", wb_valid_o, wb_src_o); end
    #1;
    arst_ni = 1'b0;
    #1;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rst_async_valid: got %b want %b", wb_valid_o, 1'b0); end
    total++; if (src_ready_o !== 4'b0000) begin bad++; $display("FAIL rst_async_ready: got %b want %b", src_ready_o, 4'b0000); end
    arst_ni = 1'b1;
    #1;
    total++; if (src_ready_o !== 4'b0001) begin bad++; $display("FAIL rst_regrant_ready: got %b want %b", src_ready_o, 4'b0001); end
    @(posedge clk_i); #1;
    total++; if (wb_valid_o !== 1'b1 || wb_src_o !== 2'd0 || wb_itag_o !== 8'h10) begin bad++; $display("FAIL rst_regrant_out: got v=%b s=%0d t=%h want v=1 s=0 t=10", wb_valid_o, wb_src_o, wb_itag_o); end
    flush_idle();
  endtask

  task automatic test_fairness();
    int exp_src;
    logic [N-1:0] exp_rdy;
    do_reset();
    wb_ready_i = 1'b1;
    src_valid_i = 4'b1111;
    #1;
    total++; if (src_ready_o !== 4'b0001) begin bad++; $display("FAIL fair_ready0: got %b want %b", src_ready_o, 4'b0001); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1;
      exp_src = k % N;
      exp_rdy = 4'b0001 << ((k + 1) % N);
      total++; if (wb_valid_o !== 1'b1 || wb_src_o !== PW'(exp_src)) begin bad++; $display("FAIL fair_src%0d: got v=%b s=%0d want v=1 s=%0d", k, wb_valid_o, wb_src_o, exp_src); end
      total++; if (wb_itag_o !== t_ref[exp_src] || wb_data_o !== d_ref[exp_src] || wb_csrdata_o !== c_ref[exp_src]) begin bad++; $display("FAIL fair_payload%0d: got t=%h d=%h want t=%h d=%h", k, wb_itag_o, wb_data_o, t_ref[exp_src], d_ref[exp_src]); end
      total++; if (src_ready_o !== exp_rdy) begin bad++; $display("FAIL fair_ready%0d: got %b want %b", k + 1, src_ready_o, exp_rdy); end
    end
    flush_idle();
  endtask

  // Pointer is at 1 here; only src0 requests, so the search must wrap.
  task automatic test_skip_idle();
    src_valid_i = 4'b0001;
    #1;
    total++; if (src_ready_o !== 4'b0001) begin bad++; $display("FAIL skip_ready: got %b want %b", src_ready_o, 4'b0001); end
    @(posedge clk_i); #1;
    total++; if (wb_valid_o !== 1'b1 || wb_src_o !== PW'(WB_SRC_ALU)) begin bad++; $display("FAIL skip_out: got v=%b s=%0d want v=1 s=0", wb_valid_o, wb_src_o); end
    src_valid_i = 4'b0011;
    #1;
    total++; if (src_ready_o !== 4'b0010) begin bad++; $display("FAIL skip_ptr: got %b want %b", src_ready_o, 4'b0010); end
    flush_idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_src(0, 64'h0000_0000_0000_1200, 64'h0000_0000_0000_0C12, 8'h12);
    set_src(1, 64'h0000_0000_0000_3400, 64'h0000_0000_0000_0C34, 8'h34);
    wb_ready_i = 1'b1;
    src_valid_i = 4'b0011;
    @(posedge clk_i); #1;
    total++; if (wb_valid_o !== 1'b1 || wb_itag_o !== 8'h12 || wb_src_o !== 2'd0) begin bad++; $display("FAIL bp_first: got v=%b t=%h s=%0d want v=1 t=12 s=0", wb_valid_o, wb_itag_o, wb_src_o); end
    src_valid_i = 4'b0010;
    src_data_i[0 +: XL] = 64'h0BAD_0BAD_0BAD_0BAD;
    src_itag_i[0 +: TW] = 8'hEE;
    wb_ready_i = 1'b0;
    #1;
    total++; if (src_ready_o !== 4'b0000) begin bad++; $display("FAIL bp_ready_hold: got %b want %b", src_ready_o, 4'b0000); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      total++; if (wb_valid_o !== 1'b1 || wb_itag_o !== 8'h12 || wb_data_o !== 64'h0000_0000_0000_1200 || wb_src_o !== 2'd0) begin bad++; $display("FAIL bp_hold%0d: got v=%b t=%h d=%h s=%0d want v=1 t=12 d=1200 s=0", k, wb_valid_o, wb_itag_o, wb_data_o, wb_src_o); end
      total++; if (src_ready_o !== 4'b0000) begin bad++; $display("FAIL bp_ready%0d: got %b want %b", k, src_ready_o, 4'b0000); end
    end
    wb_ready_i = 1'b1;
    #1;
    total++; if (src_ready_o !== 4'b0010) begin bad++; $display("FAIL bp_release_ready: got %b want %b", src_ready_o, 4'b0010); end
    @(posedge clk_i); #1;
    total++; if (wb_valid_o !== 1'b1 || wb_itag_o !== 8'h34 || wb_src_o !== PW'(WB_SRC_BRU) || wb_csrdata_o !== 64'h0000_0000_0000_0C34) begin bad++; $display("FAIL bp_next: got v=%b t=%h s=%0d want v=1 t=34 s=1", wb_valid_o, wb_itag_o, wb_src_o); end
    src_valid_i = '0;
    default_srcs();
  endtask

  // Pointer is at 2 on entry.
  task automatic test_flush();
    src_valid_i = 4'b0110;
    #1;
    total++; if (src_ready_o !== 4'b0100) begin bad++; $display("FAIL fl_pre_ready: got %b want %b", src_ready_o, 4'b0100); end
    @(posedge clk_i); #1;
    total++; if (wb_valid_o !== 1'b1 || wb_src_o !== PW'(WB_SRC_MDU)) begin bad++; $display("FAIL fl_pre_out: got v=%b s=%0d want v=1 s=2", wb_valid_o, wb_src_o); end
    flush_i = 1'b1;
    #1;
    total++; if (src_ready_o !== 4'b0000) begin bad++; $display("FAIL fl_ready: got %b want %b", src_ready_o, 4'b0000); end
    @(posedge clk_i); #1;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL fl_valid: got %b want %b", wb_valid_o, 1'b0); end
    flush_i = 1'b0;
    src_valid_i = 4'b1111;
    #1;
    total++; if (src_ready_o !== N'(1 << WB_SRC_LSU)) begin bad++; $display("FAIL fl_ptr: got %b want %b", src_ready_o, 4'b1000); end
    flush_idle();
  endtask

  // Pointer is at 3; the lone ALU request wraps around.
  task automatic test_drain();
    wb_payload_t exp_pl;
    exp_pl.data    = 64'hFFFF_FFFF_8000_0000;
    exp_pl.csrdata = 64'h0000_0000_0000_0300;
    exp_pl.itag    = 8'h5A;
    set_src(WB_SRC_ALU, exp_pl.data, exp_pl.csrdata, exp_pl.itag);
    wb_ready_i = 1'b1;
    src_valid_i = 4'b0001;
    @(posedge clk_i); #1;
    total++; if (wb_valid_o !== 1'b1 || wb_src_o !== PW'(WB_SRC_ALU)) begin bad++; $display("FAIL drain_out: got v=%b s=%0d want v=1 s=0", wb_valid_o, wb_src_o); end
    total++; if (wb_data_o !== exp_pl.data || wb_csrdata_o !== exp_pl.csrdata || wb_itag_o !== exp_pl.itag) begin bad++; $display("FAIL drain_payload: got d=%h c=%h t=%h want d=%h c=%h t=%h", wb_data_o, wb_csrdata_o, wb_itag_o, exp_pl.data, exp_pl.csrdata, exp_pl.itag); end
    src_valid_i = '0;
    @(posedge clk_i); #1;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL drain_drop: got %b want %b", wb_valid_o, 1'b0); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    arst_ni     = 1'b0;
    flush_i     = 1'b0;
    wb_ready_i  = 1'b1;
    src_valid_i = '0;
    src_data_i    = '0;
    src_csrdata_i = '0;
    src_itag_i    = '0;
    default_srcs();

    test_reset();
    test_fairness();
    test_skip_idle();
    test_backpressure();
    test_flush();
    test_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
